// File: rtl/storage_arb_pkg.sv
// storage_arb_pkg: shared arbitration modes, FSM states and storage widths
package storage_arb_pkg;
  localparam int ARB_PRIO = 0;
  localparam int ARB_RR = 1;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;
endpackage

// File: rtl/storage_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, search starts at ptr and wraps modulo N
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  always_comb begin
    int j;
    logic found;
    gnt = '0;
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        gnt[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/storage_arbiter.sv
// storage_arbiter: N_REQ requesters onto single-port storage with burst lock and tagged read return
module storage_arbiter
  import storage_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1,
  parameter int ARB_MODE = ARB_RR,
  parameter int LOCK_MAX = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ-1:0]           i_we,
  input  logic [N_REQ-1:0]           i_lock,
  input  logic [N_REQ*ADDR_W-1:0]    i_addr,
  input  logic [N_REQ*DATA_W-1:0]    i_wdata,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [N_REQ-1:0]           o_rvalid,
  output logic [DATA_W-1:0]          o_rdata,
  output logic                       o_mem_we,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic [DATA_W-1:0]          o_mem_wdata,
  input  logic [DATA_W-1:0]          i_mem_rdata,
  output logic [$clog2(N_REQ)-1:0]   o_owner,
  output logic                       o_locked,
  output logic                       o_lock_err
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LOCK_MAX + 1);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, pick_idx, gnt_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] pick_gnt, gnt;
  logic [RD_LAT-1:0] tag_v_q, tag_v_d;
  logic [RD_LAT-1:0][IW-1:0] tag_id_q, tag_id_d;
  logic locked, forced, any_gnt;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] k);
    return (k == IW'(N_REQ - 1)) ? '0 : k + 1'b1;
  endfunction

  // Requests are masked during reset so nothing is granted or queued then
  rr_pick #(.N(N_REQ)) u_pick (
    .req(i_req & {N_REQ{~rst}}),
    .ptr((ARB_MODE == ARB_RR) ? ptr_q : '0),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );

  always_comb begin
    locked = state_q == ST_LOCKED;
    forced = locked && cnt_q == CW'(LOCK_MAX);
    gnt = locked ? ((!rst && !forced && i_req[owner_q]) ? N_REQ'(1) << owner_q : '0) : pick_gnt;
    gnt_idx = locked ? owner_q : pick_idx;
    any_gnt = |gnt;
    state_d = state_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    ptr_d = any_gnt ? nxt(gnt_idx) : ptr_q;
    if (locked) begin
      if (forced || !i_lock[owner_q]) begin
        state_d = ST_IDLE;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (forced) ptr_d = nxt(owner_q);
    end else if (any_gnt && i_lock[pick_idx]) begin
      state_d = ST_LOCKED;
      owner_d = pick_idx;
      cnt_d = CW'(1);
    end
    tag_v_d[0] = any_gnt && !i_we[gnt_idx];
    tag_id_d[0] = gnt_idx;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
    o_gnt = gnt;
    o_mem_we = any_gnt && i_we[gnt_idx];
    o_mem_addr = any_gnt ? i_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
    o_mem_wdata = any_gnt ? i_wdata[gnt_idx*DATA_W +: DATA_W] : '0;
    o_rvalid = tag_v_q[RD_LAT-1] ? N_REQ'(1) << tag_id_q[RD_LAT-1] : '0;
    o_rdata = tag_v_q[RD_LAT-1] ? i_mem_rdata : '0;
    o_owner = owner_q;
    o_locked = locked;
    o_lock_err = forced && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      tag_v_q <= '0;
      tag_id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      tag_v_q <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end
endmodule
